bkg_calib_ctrl: RTL and testbench



---
 rtl/bkg_calib_ctrl_pkg.sv | 32 +++
 rtl/bkg_calib_ctrl_frame_tracker.sv | 40 ++++
 rtl/bkg_calib_ctrl.sv | 134 +++++++++++++
 tb/tb_bkg_calib_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bkg_calib_ctrl_pkg.sv
// Shared encodings for the background-calibration controller: pipe modes,
// FSM states and the CSR register map.
package bkg_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_CLEAR    = 2'd1,
    MODE_SUBTRACT = 2'd2,
    MODE_ACCUM    = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_CLEAR    = 3'd2,
    ST_ACCUM    = 3'd3,
    ST_SUBTRACT = 3'd4
  } state_t;

  localparam logic [1:0] CSR_CTRL      = 2'd0;
  localparam logic [1:0] CSR_STATUS    = 2'd1;
  localparam logic [1:0] CSR_FRAME_ID  = 2'd2;
  localparam logic [1:0] CSR_ACCUM_CNT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_K_LSB  = 4;
  localparam int STAT_DONE   = 4;
  localparam int STAT_ERR    = 5;

endpackage

// File: rtl/bkg_calib_ctrl_frame_tracker.sv
// Follows the pipe's input-side packet framing: SOP edge detect, frame count,
// in-frame flag, frame-boundary pulse and double-SOP error pulse.
module frame_tracker #(
  parameter int FID_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_sop,
  input  logic             frame_eop,
  output logic             in_frame,
  output logic [FID_W-1:0] frame_id,
  output logic             boundary,
  output logic             err
);

  logic sop_q;
  logic sop_rise;

  assign sop_rise = frame_sop & ~sop_q;
  assign boundary = frame_eop & in_frame;
  // An SOP edge coinciding with the closing EOP opens the next frame legally.
  assign err      = sop_rise & in_frame & ~boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_q    <= 1'b0;
      in_frame <= 1'b0;
      frame_id <= '0;
    end else begin
      sop_q <= frame_sop;
      if (sop_rise) begin
        frame_id <= frame_id + FID_W'(1);
        in_frame <= 1'b1;
      end else if (boundary) begin
        in_frame <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bkg_calib_ctrl.sv
// Host-commanded background calibration: clear, accumulate 2^k frames, then
// subtract, with every mode change aligned to a frame gap.
module bkg_calib_ctrl
  import bkg_ctrl_pkg::*;
#(
  parameter int LOG2_MAX = 6,
  parameter int FID_W    = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       csr_address,
  input  logic             csr_read,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  output logic [31:0]      csr_readdata,
  input  logic             frame_sop,
  input  logic             frame_eop,
  output logic [1:0]       bkg_mode,
  output logic [2:0]       bkg_shift,
  output logic [FID_W-1:0] frame_id,
  output logic             busy,
  output logic             irq
);

  localparam logic [2:0] K_MAX = (LOG2_MAX >= 7) ? 3'd7 : 3'(LOG2_MAX);

  logic       in_frame, boundary, err_pulse;
  state_t     state;
  mode_t      mode_r;
  logic [2:0] k_lat;
  logic       abort_pend, done_sticky, err_sticky, irq_en;
  logic [7:0] accum_cnt;

  frame_tracker #(.FID_W(FID_W)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_sop (frame_sop),
    .frame_eop (frame_eop),
    .in_frame  (in_frame),
    .frame_id  (frame_id),
    .boundary  (boundary),
    .err       (err_pulse)
  );

  logic       wr_ctrl, wr_stat, cmd_start, cmd_abort, abort_now;
  logic [2:0] k_req, k_clamped;
  logic [7:0] accum_nxt, accum_tgt;
  logic       unused_wdata;

  assign wr_ctrl   = csr_write && (csr_address == CSR_CTRL);
  assign wr_stat   = csr_write && (csr_address == CSR_STATUS);
  assign cmd_abort = wr_ctrl & csr_writedata[CTRL_ABORT];
  assign cmd_start = wr_ctrl & csr_writedata[CTRL_START] & ~csr_writedata[CTRL_ABORT];
  assign abort_now = (cmd_abort && (state != ST_IDLE)) || abort_pend;
  assign k_req     = csr_writedata[CTRL_K_LSB +: 3];
  assign k_clamped = (k_req > K_MAX) ? K_MAX : k_req;
  assign accum_nxt = accum_cnt + 8'd1;
  assign accum_tgt = 8'd1 << bkg_shift;
  assign unused_wdata = ^{csr_writedata[31:7], csr_writedata[3]};

  assign busy     = (state == ST_ARM) || (state == ST_CLEAR) || (state == ST_ACCUM);
  assign irq      = done_sticky & irq_en;
  assign bkg_mode = mode_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_r      <= MODE_BYPASS;
      k_lat       <= '0;
      bkg_shift   <= '0;
      abort_pend  <= 1'b0;
      done_sticky <= 1'b0;
      err_sticky  <= 1'b0;
      irq_en      <= 1'b0;
      accum_cnt   <= '0;
    end else begin
      if (wr_ctrl) irq_en <= csr_writedata[CTRL_IRQ_EN];
      if (wr_stat && csr_writedata[STAT_DONE]) done_sticky <= 1'b0;
      if (wr_stat && csr_writedata[STAT_ERR])  err_sticky  <= 1'b0;
      if (err_pulse) err_sticky <= 1'b1;

      // Restart leaves the mode alone: it only moves at the next gap (ARM -> CLEAR),
      // so a frame already in flight keeps the mode it was opened with.
      if (abort_now && (!in_frame || boundary)) begin
        state      <= ST_IDLE;
        mode_r     <= MODE_BYPASS;
        abort_pend <= 1'b0;
      end else if (cmd_start) begin
        state      <= ST_ARM;
        k_lat      <= k_clamped;
        abort_pend <= 1'b0;
      end else if (abort_now) begin
        abort_pend <= 1'b1;
      end else begin
        unique case (state)
          ST_ARM: if (!in_frame || boundary) begin
            state     <= ST_CLEAR;
            mode_r    <= MODE_CLEAR;
            bkg_shift <= k_lat;
          end
          ST_CLEAR: if (boundary) begin
            state     <= ST_ACCUM;
            mode_r    <= MODE_ACCUM;
            accum_cnt <= '0;
          end
          ST_ACCUM: if (boundary) begin
            accum_cnt <= accum_nxt;
            if (accum_nxt == accum_tgt) begin
              state       <= ST_SUBTRACT;
              mode_r      <= MODE_SUBTRACT;
              done_sticky <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      unique case (csr_address)
        CSR_CTRL:      csr_readdata <= '0;
        CSR_STATUS:    csr_readdata <= {26'd0, err_sticky, done_sticky, busy, state};
        CSR_FRAME_ID:  csr_readdata <= 32'(frame_id);
        CSR_ACCUM_CNT: csr_readdata <= 32'(accum_cnt);
        default:       csr_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bkg_calib_ctrl.sv
// Scoreboard bench for bkg_calib_ctrl: per-frame mode and CSR read results are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_bkg_calib_ctrl;
  import bkg_ctrl_pkg::*;

  localparam int FID_W = 27;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       csr_address = '0;
  logic             csr_read = 1'b0;
  logic             csr_write = 1'b0;
  logic [31:0]      csr_writedata = '0;
  logic [31:0]      csr_readdata;
  logic             frame_sop = 1'b0;
  logic             frame_eop = 1'b0;
  logic [1:0]       bkg_mode;
  logic [2:0]       bkg_shift;
  logic [FID_W-1:0] frame_id;
  logic             busy;
  logic             irq;

  bkg_calib_ctrl #(.LOG2_MAX(6), .FID_W(FID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .frame_sop     (frame_sop),
    .frame_eop     (frame_eop),
    .bkg_mode      (bkg_mode),
    .bkg_shift     (bkg_shift),
    .frame_id      (frame_id),
    .busy          (busy),
    .irq           (irq)
  );

  initial forever #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          fid_exp = 0;
  logic [1:0]  mode_q[$];
  logic [31:0] rd_q[$];
  string       rd_tag_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pipe samples the mode in the cycle after its SOP edge; read data is valid the cycle after a read.
  logic sop_p = 1'b0, mchk = 1'b0, rchk = 1'b0;
  always @(posedge clk) begin
    sop_p <= frame_sop;
    mchk  <= frame_sop & ~sop_p;
    rchk  <= csr_read;
  end

  always @(negedge clk) begin
    if (mchk) begin
      if (mode_q.size() == 0) check_val("mode_unexpected", 32'(mode_q.size()), 32'd1);
      else check_val("frame_mode", 32'(bkg_mode), 32'(mode_q.pop_front()));
    end
    if (rchk) begin
      if (rd_q.size() == 0) check_val("read_unexpected", 32'(rd_q.size()), 32'd1);
      else check_val(rd_tag_q.pop_front(), csr_readdata, rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0; csr_writedata = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    csr_address = a; csr_read = 1'b1;
    rd_q.push_back(exp);
    rd_tag_q.push_back(tag);
    tick();
    csr_read = 1'b0;
    tick();
  endtask

  task automatic frame(input logic [1:0] m, input int len, input int wr_at = -1,
                       input logic [1:0] wa = '0, input logic [31:0] wd = '0);
    mode_q.push_back(m);
    fid_exp++;
    frame_sop = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == wr_at) begin
        csr_address = wa; csr_writedata = wd; csr_write = 1'b1;
      end
      tick();
      csr_write = 1'b0;
    end
    frame_eop = 1'b1;
    tick();
    frame_eop = 1'b0;
    frame_sop = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_val("rst_mode", 32'(bkg_mode), 32'(MODE_BYPASS));
    check_val("rst_shift", 32'(bkg_shift), 32'd0);
    check_val("rst_fid", 32'(frame_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    csr_rd(CSR_STATUS, 32'h0, "rst_status");

    // k=2, start written mid-frame 1
    frame(MODE_BYPASS, 6, 2, CSR_CTRL, 32'h21);
    frame(MODE_CLEAR, 6);
    repeat (4) frame(MODE_ACCUM, 6);
    frame(MODE_SUBTRACT, 6);
    check_val("k2_shift", 32'(bkg_shift), 32'd2);
    check_val("k2_busy", 32'(busy), 32'd0);
    check_val("k2_irq_off", 32'(irq), 32'd0);
    csr_rd(CSR_STATUS, 32'h14, "k2_status");
    csr_rd(CSR_ACCUM_CNT, 32'd4, "k2_accum_cnt");
    csr_rd(CSR_FRAME_ID, 32'(fid_exp), "k2_frame_id");

    // restart between frames, abort mid-ACCUM mid-frame
    csr_wr(CSR_STATUS, 32'h10);
    csr_wr(CSR_CTRL, 32'h21);
    frame(MODE_CLEAR, 6);
    frame(MODE_ACCUM, 6, 2, CSR_CTRL, 32'h02);
    check_val("abort_busy", 32'(busy), 32'd0);
    frame(MODE_BYPASS, 6);
    csr_rd(CSR_STATUS, 32'h0, "abort_status");

    // k=7 clamps to LOG2_MAX=6: exactly 64 ACCUM frames
    csr_wr(CSR_CTRL, 32'h71);
    frame(MODE_CLEAR, 2);
    repeat (64) frame(MODE_ACCUM, 2);
    frame(MODE_SUBTRACT, 2);
    check_val("k7_shift", 32'(bkg_shift), 32'd6);
    csr_rd(CSR_ACCUM_CNT, 32'd64, "k7_accum_cnt");
    csr_rd(CSR_STATUS, 32'h14, "k7_status");

    // double SOP without EOP
    mode_q.push_back(MODE_SUBTRACT); fid_exp++;
    frame_sop = 1'b1; repeat (3) tick();
    frame_sop = 1'b0; tick();
    mode_q.push_back(MODE_SUBTRACT); fid_exp++;
    frame_sop = 1'b1; repeat (3) tick();
    frame_sop = 1'b0; repeat (2) tick();
    check_val("dsop_fid", 32'(frame_id), 32'(fid_exp));
    csr_rd(CSR_STATUS, 32'h34, "dsop_status");
    frame_eop = 1'b1; tick();
    frame_eop = 1'b0; tick();
    check_val("dsop_mode", 32'(bkg_mode), 32'(MODE_SUBTRACT));
    csr_wr(CSR_STATUS, 32'h20);
    csr_rd(CSR_STATUS, 32'h14, "err_w1c_status");

    // irq on SUBTRACT entry, W1C drop
    csr_wr(CSR_STATUS, 32'h10);
    csr_wr(CSR_CTRL, 32'h15);
    frame(MODE_CLEAR, 4);
    check_val("irq_pre", 32'(irq), 32'd0);
    repeat (2) frame(MODE_ACCUM, 4);
    check_val("irq_set", 32'(irq), 32'd1);
    csr_wr(CSR_STATUS, 32'h10);
    check_val("irq_w1c", 32'(irq), 32'd0);
    csr_rd(CSR_STATUS, 32'h04, "irq_status");

    // reset pulse mid-ACCUM, mid-frame
    csr_wr(CSR_CTRL, 32'h15);
    frame(MODE_CLEAR, 4);
    mode_q.push_back(MODE_ACCUM); fid_exp++;
    frame_sop = 1'b1; repeat (3) tick();
    check_val("pre_rst_mode", 32'(bkg_mode), 32'(MODE_ACCUM));
    rst_n = 1'b0; frame_sop = 1'b0;
    #1;
    fid_exp = 0;
    check_val("rst_async_mode", 32'(bkg_mode), 32'(MODE_BYPASS));
    check_val("rst_async_fid", 32'(frame_id), 32'(fid_exp));
    check_val("rst_async_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    csr_rd(CSR_STATUS, 32'h0, "post_rst_status");
    csr_rd(CSR_FRAME_ID, 32'(fid_exp), "post_rst_fid");

    repeat (2) tick();
    check_val("mode_q_left", 32'(mode_q.size()), 32'd0);
    check_val("rd_q_left", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
